// File: rtl/alu_mdu_if.sv
// alu_mdu_if: handshake and data bundle between the execute stage and alu_mdu.
//   master : pipeline side (drives operation fields, in_valid, ras)
//   slave  : alu_mdu side (drives in_ready, out_valid, busC, take_jmp)
// Signals:
//   in_valid/in_ready   request handshake
//   opcode/funct3/funct7 decoded instruction fields
//   busA/busB/imm/pc    operands
//   ras                 return-address-stack hit, suppresses take_jmp
//   out_valid           one-cycle result strobe
//   busC/take_jmp       result and redirect request
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] busA;
  logic [XLEN-1:0] busB;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            ras;
  logic            out_valid;
  logic [XLEN-1:0] busC;
  logic            take_jmp;

  modport master (
    output in_valid, opcode, funct3, funct7, busA, busB, imm, pc, ras,
    input  in_ready, out_valid, busC, take_jmp
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, busA, busB, imm, pc, ras,
    output in_ready, out_valid, busC, take_jmp
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: registered RV32I ALU / branch / jump / address unit with an
// iterative RV32M multiplier (shift-add) and restoring divider.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    alu_mdu_if.slave (operation in, result out, valid/ready)
// Build option:
//   ALU_MDU_DIV_EN  defined   -> divider built, DIV group iterates XLEN cycles
//                   undefined -> DIV group returns 0 in one cycle
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// MUL   | one partial-product add per cycle
// DIV   | one quotient bit per cycle
// DONE  | out_valid pulse, busC/take_jmp hold the result
module alu_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mdu_if.slave bus
);
  localparam int         SH_W       = $clog2(XLEN);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_M       = 7'b0000001;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // {hi, lo}: product or {remainder, quotient}
  logic [XLEN-1:0]   opd_q, opd_d;   // multiplicand or divisor magnitude
  logic              neg_q, neg_d;   // product / quotient sign
  logic              sel_q, sel_d;   // high half (mul) or remainder (div)
  logic [XLEN-1:0]   busc_q, busc_d;
  logic              take_q, take_d;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  // Base ALU
  logic            is_reg, is_m, f7_zero, f7_alt, f7_ok;
  logic [XLEN-1:0] alu_y, alu_res;
  logic [SH_W-1:0] shamt;
  logic            alu_take;

  assign is_reg  = bus.opcode == OPC_OP;
  assign is_m    = is_reg && (bus.funct7 == F7_M);
  assign f7_zero = bus.funct7 == 7'b0000000;
  assign f7_alt  = bus.funct7 == F7_ALT;
  assign f7_ok   = !is_reg || f7_zero;  // immediate forms carry imm bits in funct7
  assign alu_y   = is_reg ? bus.busB : bus.imm;
  assign shamt   = alu_y[SH_W-1:0];

  always_comb begin
    alu_res  = '0;
    alu_take = 1'b0;
    case (bus.opcode)
      OPC_OP, OPC_OPIMM: begin
        case (bus.funct3)
          3'b000: if (f7_ok) alu_res = bus.busA + alu_y;
                  else if (f7_alt) alu_res = bus.busA - alu_y;
          3'b001: if (f7_zero) alu_res = bus.busA << shamt;
          3'b010: if (f7_ok) alu_res = {{(XLEN-1){1'b0}}, $signed(bus.busA) < $signed(alu_y)};
          3'b011: if (f7_ok) alu_res = {{(XLEN-1){1'b0}}, bus.busA < alu_y};
          3'b100: if (f7_ok) alu_res = bus.busA ^ alu_y;
          3'b101: if (f7_zero) alu_res = bus.busA >> shamt;
                  else if (f7_alt) alu_res = $signed(bus.busA) >>> shamt;
          3'b110: if (f7_ok) alu_res = bus.busA | alu_y;
          3'b111: if (f7_ok) alu_res = bus.busA & alu_y;
        endcase
      end
      OPC_LUI:            alu_res = bus.imm;
      OPC_AUIPC:          alu_res = bus.pc + bus.imm;
      OPC_JAL, OPC_JALR: begin
        alu_res  = bus.pc + XLEN'(4);
        alu_take = 1'b1;
      end
      OPC_BRANCH: begin
        case (bus.funct3)
          3'b000:  alu_take = bus.busA == bus.busB;
          3'b001:  alu_take = bus.busA != bus.busB;
          3'b100:  alu_take = $signed(bus.busA) <  $signed(bus.busB);
          3'b101:  alu_take = $signed(bus.busA) >= $signed(bus.busB);
          3'b110:  alu_take = bus.busA <  bus.busB;
          3'b111:  alu_take = bus.busA >= bus.busB;
          default: alu_take = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_STORE: alu_res = bus.busA + bus.imm;
      default:             alu_res = '0;
    endcase
  end

  // Multiplier step: add multiplicand on low bit, shift the whole accumulator right
  logic              mul_sa, mul_sb;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  logic [XLEN-1:0]   mul_res;

  assign mul_sa   = (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
  assign mul_sb   = bus.funct3[1:0] == 2'b01;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;
  assign mul_res  = sel_q ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];

`ifdef ALU_MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              rneg_q, rneg_d;  // remainder follows dividend sign
  logic              div_s;
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_q, div_r, div_res;

  assign div_s    = !bus.funct3[0];
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opd_q};
  // Borrow out means the trial subtract failed: restore and shift in 0
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign div_q    = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
  assign div_r    = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
  assign div_res  = sel_q ? div_r : div_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    neg_d   = neg_q;
    sel_d   = sel_q;
    busc_d  = busc_q;
    take_d  = take_q;
`ifdef ALU_MDU_DIV_EN
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_DONE;
          take_d  = 1'b0;
          if (is_m && !bus.funct3[2]) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(XLEN - 1);
            acc_d   = {{XLEN{1'b0}}, mag(bus.busB, mul_sb)};
            opd_d   = mag(bus.busA, mul_sa);
            neg_d   = (mul_sa & bus.busA[XLEN-1]) ^ (mul_sb & bus.busB[XLEN-1]);
            sel_d   = bus.funct3[1:0] != 2'b00;
          end else if (is_m) begin
`ifdef ALU_MDU_DIV_EN
            sel_d = bus.funct3[1];
            if (bus.busB == '0) begin
              busc_d = bus.funct3[1] ? bus.busA : '1;
            end else if (div_s && bus.busA == MIN_NEG && bus.busB == '1) begin
              busc_d = bus.funct3[1] ? '0 : bus.busA;
            end else begin
              state_d = S_DIV;
              cnt_d   = CNT_W'(XLEN - 1);
              acc_d   = {{XLEN{1'b0}}, mag(bus.busA, div_s)};
              opd_d   = mag(bus.busB, div_s);
              neg_d   = div_s & (bus.busA[XLEN-1] ^ bus.busB[XLEN-1]);
              rneg_d  = div_s & bus.busA[XLEN-1];
            end
`else
            busc_d = '0;
`endif
          end else begin
            busc_d = alu_res;
            take_d = alu_take & ~bus.ras;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busc_d  = mul_res;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef ALU_MDU_DIV_EN
      S_DIV: begin
        acc_d = div_next;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busc_d  = div_res;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      neg_q   <= 1'b0;
      sel_q   <= 1'b0;
      busc_q  <= '0;
      take_q  <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      neg_q   <= neg_d;
      sel_q   <= sel_d;
      busc_q  <= busc_d;
      take_q  <= take_d;
`ifdef ALU_MDU_DIV_EN
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.busC      = busc_q;
  assign bus.take_jmp  = take_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vector table, hand-written multi-cycle sequences and
// randomized operations against an arithmetic reference model of alu_mdu.
module tb_alu_mdu;
  localparam int XLEN = 32;
`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, im, p;
    logic        r;
    logic [31:0] c;
    logic        t;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mdu_if #(.XLEN(XLEN)) bif();
  alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                              input logic [31:0] p, input logic r, input logic [31:0] c,
                              input logic t, input int lat);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.im = im; v.p = p; v.r = r;
    v.c = c; v.t = t; v.lat = lat;
    return v;
  endfunction

  // Reference: ISA semantics with 64-bit arithmetic and SV division
  function automatic void model(input vec_t v, output logic [31:0] c, output logic t, output int lat);
    logic [31:0]        y, q, rm;
    logic [4:0]         sh;
    logic signed [63:0] sa, sb, ps, psu;
    logic [63:0]        pu;
    bit                 reg_op, ok, f7z, f7a, dsg, cond;
    c = '0; t = 1'b0; lat = 1; q = '0; rm = '0; cond = 1'b0;
    reg_op = v.op == 7'h33;
    y   = reg_op ? v.b : v.im;
    sh  = y[4:0];
    f7z = v.f7 == 7'h00;
    f7a = v.f7 == 7'h20;
    ok  = !reg_op || f7z;
    sa  = {{32{v.a[31]}}, v.a};
    sb  = {{32{v.b[31]}}, v.b};
    if (reg_op && v.f7 == 7'h01) begin
      if (!v.f3[2]) begin
        lat = 33;
        pu  = {32'b0, v.a} * {32'b0, v.b};
        ps  = sa * sb;
        psu = sa * $signed({32'b0, v.b});
        case (v.f3[1:0])
          2'd0:    c = pu[31:0];
          2'd1:    c = ps[63:32];
          2'd2:    c = psu[63:32];
          default: c = pu[63:32];
        endcase
      end else if (DIV_EN) begin
        dsg = !v.f3[0];
        if (v.b == 0) begin
          q = '1; rm = v.a;
        end else if (dsg && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) begin
          q = v.a; rm = '0;
        end else begin
          lat = 33;
          if (dsg) begin
            q  = $signed(v.a) / $signed(v.b);
            rm = $signed(v.a) % $signed(v.b);
          end else begin
            q  = v.a / v.b;
            rm = v.a % v.b;
          end
        end
        c = v.f3[1] ? rm : q;
      end
    end else begin
      case (v.op)
        7'h33, 7'h13: begin
          case (v.f3)
            3'd0: if (ok) c = v.a + y; else if (f7a) c = v.a - y;
            3'd1: if (f7z) c = v.a << sh;
            3'd2: if (ok) c = ($signed(v.a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: if (ok) c = (v.a < y) ? 32'd1 : 32'd0;
            3'd4: if (ok) c = v.a ^ y;
            3'd5: if (f7z) c = v.a >> sh; else if (f7a) c = $signed(v.a) >>> sh;
            3'd6: if (ok) c = v.a | y;
            3'd7: if (ok) c = v.a & y;
          endcase
        end
        7'h37: c = v.im;
        7'h17: c = v.p + v.im;
        7'h6F, 7'h67: begin c = v.p + 32'd4; t = !v.r; end
        7'h63: begin
          case (v.f3)
            3'd0: cond = v.a == v.b;
            3'd1: cond = v.a != v.b;
            3'd4: cond = $signed(v.a) < $signed(v.b);
            3'd5: cond = $signed(v.a) >= $signed(v.b);
            3'd6: cond = v.a < v.b;
            3'd7: cond = v.a >= v.b;
            default: cond = 1'b0;
          endcase
          t = cond && !v.r;
        end
        7'h03, 7'h23: c = v.a + v.im;
        default: c = '0;
      endcase
    end
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic vec_t gen_rand();
    vec_t v;
    int   k;
    v = mk(7'h33, 3'($urandom_range(0, 7)), 7'h00, rnd_val(), rnd_val(), rnd_val(),
           32'($urandom) & 32'hFFFFFFFC, $urandom_range(0, 3) == 0, '0, 1'b0, 1);
    case ($urandom_range(0, 3))
      0, 1: v.f7 = 7'h00;
      2:    v.f7 = 7'h20;
      default: v.f7 = 7'($urandom_range(0, 127));
    endcase
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: v.op = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
      3: v.op = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
      4: v.op = ($urandom_range(0, 1) == 0) ? 7'h6F : 7'h67;
      5: v.op = 7'h63;
      6: begin
        case ($urandom_range(0, 2))
          0: v.op = 7'h03;
          1: v.op = 7'h23;
          default: v.op = 7'h7F;
        endcase
      end
      7, 8: begin v.op = 7'h33; v.f7 = 7'h01; v.f3 = 3'($urandom_range(0, 3)); end
      default: begin
        v.op = 7'h33; v.f7 = 7'h01; v.f3 = 3'($urandom_range(4, 7));
        if ($urandom_range(0, 4) == 0) v.b = '0;
      end
    endcase
    return v;
  endfunction

  task automatic present(input vec_t v);
    bif.opcode = v.op; bif.funct3 = v.f3; bif.funct7 = v.f7;
    bif.busA = v.a; bif.busB = v.b; bif.imm = v.im; bif.pc = v.p; bif.ras = v.r;
  endtask

  // Accept one op, measure accept-edge-to-out_valid latency, check result
  task automatic run_op(input string name, input vec_t v);
    int lat;
    bit seen;
    for (int i = 0; i < 100 && !bif.in_ready; i++) begin @(posedge clk); #1; end
    check({name, " in_ready"}, 32'(bif.in_ready), 32'd1);
    present(v);
    bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    seen = 1'b0;
    lat  = 1;
    while (!seen && lat <= 100) begin
      if (bif.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    check({name, " latency"}, 32'(lat), 32'(v.lat));
    check({name, " busC"}, bif.busC, v.c);
    check({name, " take_jmp"}, 32'(bif.take_jmp), 32'(v.t));
    @(posedge clk); #1;
  endtask

  task automatic reset_mid(input string name, input vec_t v);
    bit bad;
    present(v);
    bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check({name, " rst out_valid"}, 32'(bif.out_valid), 32'd0);
    check({name, " rst in_ready"}, 32'(bif.in_ready), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bif.out_valid) bad = 1'b1;
    end
    check({name, " no out_valid after abort"}, 32'(bad), 32'd0);
    run_op({name, " ADD after abort"}, mk(7'h33, 3'd0, 7'h00, 32'd3, 32'd4, 0, 0, 0, 32'd7, 0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    logic [31:0] ec;
    logic        et;
    int          el;
    bit          bad_ready;
    int          k;

    // op, f3, f7, a, b, imm, pc, ras, busC, take, latency
    vecs.push_back(mk(7'h33, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd1, 0, 1));      // SLT
    vecs.push_back(mk(7'h33, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 0, 1));      // SLTU
    vecs.push_back(mk(7'h63, 3'd4, 7'h00, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 32'd0, 0, 1));      // BLT ras
    vecs.push_back(mk(7'h63, 3'd4, 7'h00, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 1, 1));      // BLT
    vecs.push_back(mk(7'h33, 3'd1, 7'h01, 32'h80000000, 32'h80000000, 0, 0, 0, 32'h40000000, 0, 33)); // MULH
    vecs.push_back(mk(7'h33, 3'd0, 7'h01, 32'd7, 32'hFFFFFFFD, 0, 0, 0, 32'hFFFFFFEB, 0, 33));       // MUL
    vecs.push_back(mk(7'h33, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFE, 0, 33)); // MULHU
    vecs.push_back(mk(7'h33, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFF, 0, 33)); // MULHSU
    vecs.push_back(mk(7'h33, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 0, 0, 0,
                      DIV_EN ? 32'hFFFFFFFD : 32'h0, 0, DIV_EN ? 33 : 1));                 // DIV
    vecs.push_back(mk(7'h33, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2, 0, 0, 0,
                      DIV_EN ? 32'hFFFFFFFF : 32'h0, 0, DIV_EN ? 33 : 1));                 // REM
    vecs.push_back(mk(7'h33, 3'd5, 7'h01, 32'd5, 32'd0, 0, 0, 0,
                      DIV_EN ? 32'hFFFFFFFF : 32'h0, 0, 1));                               // DIVU /0
    vecs.push_back(mk(7'h33, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 0, 1)); // REM ovf
    vecs.push_back(mk(7'h33, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0,
                      DIV_EN ? 32'h80000000 : 32'h0, 0, 1));                               // DIV ovf
    vecs.push_back(mk(7'h33, 3'd5, 7'h01, 32'hFFFFFFFF, 32'd3, 0, 0, 0,
                      DIV_EN ? 32'h55555555 : 32'h0, 0, DIV_EN ? 33 : 1));                 // DIVU
    vecs.push_back(mk(7'h33, 3'd7, 7'h01, 32'd7, 32'd3, 0, 0, 0,
                      DIV_EN ? 32'd1 : 32'h0, 0, DIV_EN ? 33 : 1));                        // REMU
    vecs.push_back(mk(7'h6F, 3'd0, 7'h00, 0, 0, 32'h40, 32'h100, 0, 32'h104, 1, 1));       // JAL
    vecs.push_back(mk(7'h13, 3'd5, 7'h20, 32'h80000000, 0, 32'h404, 0, 0, 32'hF8000000, 0, 1)); // SRAI
    vecs.push_back(mk(7'h33, 3'd0, 7'h20, 32'd5, 32'd7, 0, 0, 0, 32'hFFFFFFFE, 0, 1));     // SUB
    vecs.push_back(mk(7'h33, 3'd1, 7'h10, 32'd5, 32'd1, 0, 0, 0, 32'h0, 0, 1));            // bad funct7
    vecs.push_back(mk(7'h33, 3'd5, 7'h00, 32'h80000000, 32'h21, 0, 0, 0, 32'h40000000, 0, 1)); // SRL
    vecs.push_back(mk(7'h17, 3'd0, 7'h00, 0, 0, 32'h2000, 32'h1000, 0, 32'h3000, 0, 1));   // AUIPC
    vecs.push_back(mk(7'h37, 3'd0, 7'h00, 0, 0, 32'hABCDE000, 0, 0, 32'hABCDE000, 0, 1));  // LUI
    vecs.push_back(mk(7'h63, 3'd7, 7'h00, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 0, 1));     // BGEU
    vecs.push_back(mk(7'h63, 3'd1, 7'h00, 32'd1, 32'd2, 0, 0, 0, 32'h0, 1, 1));            // BNE
    vecs.push_back(mk(7'h03, 3'd2, 7'h00, 32'h1000, 0, 32'hFFFFFFFC, 0, 0, 32'hFFC, 0, 1)); // LOAD
    vecs.push_back(mk(7'h7F, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 32'd4, 0, 32'h0, 0, 1));    // unknown

    bif.in_valid = 1'b1;
    present(mk(7'h33, 3'd0, 7'h00, 32'd9, 32'd9, 0, 0, 0, 0, 0, 1));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busC", bif.busC, 32'h0);
    check("reset out_valid", 32'(bif.out_valid), 32'd0);
    check("reset take_jmp", 32'(bif.take_jmp), 32'd0);
    check("reset in_ready", 32'(bif.in_ready), 32'd1);
    rst_n = 1'b1;
    bif.in_valid = 1'b0;
    @(posedge clk); #1;
    check("post-reset in_ready", 32'(bif.in_ready), 32'd1);
    check("post-reset out_valid", 32'(bif.out_valid), 32'd0);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // MULH with a second op held during the iteration
    present(mk(7'h33, 3'd1, 7'h01, 32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, 1));
    bif.in_valid = 1'b1;
    @(posedge clk); #1;
    present(mk(7'h33, 3'd0, 7'h00, 32'd3, 32'd4, 0, 0, 0, 0, 0, 1));
    bad_ready = 1'b0;
    k = 1;
    while (!bif.out_valid && k <= 60) begin
      if (bif.in_ready) bad_ready = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    check("stall in_ready low", 32'(bad_ready), 32'd0);
    check("stall MULH latency", 32'(k), 32'd33);
    check("stall MULH busC", bif.busC, 32'h40000000);
    check("stall DONE in_ready", 32'(bif.in_ready), 32'd0);
    @(posedge clk); #1;
    check("stall idle out_valid", 32'(bif.out_valid), 32'd0);
    check("stall idle in_ready", 32'(bif.in_ready), 32'd1);
    check("stall busC held", bif.busC, 32'h40000000);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    check("held op out_valid", 32'(bif.out_valid), 32'd1);
    check("held op busC", bif.busC, 32'd7);
    @(posedge clk); #1;

    reset_mid("abort DIV", mk(7'h33, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 0, 1));
    reset_mid("abort MUL", mk(7'h33, 3'd0, 7'h01, 32'd7, 32'd9, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 150; i++) begin
      v = gen_rand();
      model(v, ec, et, el);
      v.c = ec; v.t = et; v.lat = el;
      run_op($sformatf("rand%0d op=%h f3=%0d f7=%h a=%h b=%h", i, v.op, v.f3, v.f7, v.a, v.b), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
